swap_cmd_sequencer: RTL
=======================

Name: swap_cmd_sequencer

Overview:
Command front end that sits directly upstream of the swap register file and drives its write and swap ports. Accepts write and swap commands from a host over a valid/ready handshake and buffers them in a small FIFO. Issues at most one command per cycle as a single-cycle registered strobe (write_en or swap). Supports issue pause (hold), queue flush, and filtering of degenerate swaps.

Parameters:
ADDR_WIDTH, 7, register-file address width.
DATA_WIDTH, 8, register-file data width.
FIFO_DEPTH, 4, command queue entries; power of 2, >= 2.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  host presents a command.
cmd_ready  out  1  queue can accept; a transfer occurs when cmd_valid && cmd_ready at a rising edge.
cmd_op  in  1  0 = write, 1 = swap.
cmd_addr_a  in  ADDR_WIDTH  write address, or swap location A.
cmd_addr_b  in  ADDR_WIDTH  swap location B; ignored for writes.
cmd_data  in  DATA_WIDTH  write data; ignored for swaps.
hold  in  1  1 = do not pop or issue this cycle.
flush  in  1  synchronous clear of all queued commands.
write_en  out  1  one-cycle write strobe to register file.
address_w  out  ADDR_WIDTH  write address.
data_w  out  DATA_WIDTH  write data.
swap  out  1  one-cycle swap strobe to register file.
address_A  out  ADDR_WIDTH  swap location A.
address_B  out  ADDR_WIDTH  swap location B.
busy  out  1  queue non-empty or a strobe is active.
drop_count  out  8  count of discarded A==B swaps, saturating.

Behaviour:
- Reset (async, any time): queue empties and pointers clear. All outputs go to 0, except cmd_ready, which is 1. Commands queued or in flight are lost. No strobe occurs in the first cycle after release.
- cmd_ready = !full. It is combinational from the occupancy count. When full, no push is accepted, even if a pop occurs in the same cycle.
- Pop rule: at each rising edge, pop the head if the queue is non-empty, hold = 0 and flush = 0.
- Output registers: all outputs load on the popping edge and are valid for exactly one cycle.
- Write pop: write_en = 1; address_w = head addr_a; data_w = head data.
- Swap pop, A != B: swap = 1; address_A = head addr_a; address_B = head addr_b.
- Swap pop, A == B: consumed with no strobe; drop_count increments and saturates at 255.
- Non-pop cycles: write_en = 0 and swap = 0. Address and data outputs hold their last loaded values.
- The write and swap strobes are never both 1.
- Latency: with an empty queue and hold = 0, a command accepted at edge k strobes in the cycle after edge k+1. Back-to-back accepts produce back-to-back strobes, one per cycle, in FIFO order.
- Simultaneous push and pop on a non-full queue: both occur; occupancy is unchanged.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH)-bit and wrap modulo FIFO_DEPTH. The occupancy counter is log2(FIFO_DEPTH)+1 bits.
- flush = 1:
  - Queue clears at the edge.
  - A push in the same cycle is discarded.
  - No pop occurs.
  - Strobes are 0 in the next cycle.
  - drop_count is unchanged.
- hold = 1: no pop. Strobes are 0 in the next cycle. Pushes are still accepted until full.
- FSM (state register plus occupancy):
  - EMPTY: no entries.
  - RUN: entries present and hold = 0.
  - PAUSED: entries present and hold = 1.
  - EMPTY -> RUN on push.
  - RUN -> EMPTY when the last entry pops with no push.
  - RUN <-> PAUSED follows hold.
  - Any state -> EMPTY on flush or reset.
- busy = (state != EMPTY) || write_en || swap.

Test Plan:
- Reset: pulse reset for 2 ns mid-cycle with 3 commands queued -> all outputs 0, cmd_ready = 1, drop_count = 0; no strobe after release.
- Streaming writes: 10 back-to-back writes, addr 20..29, data = addr, hold = 0 -> write_en high for 10 consecutive cycles starting one cycle after the first accept; address_w/data_w step 20..29; busy drops the cycle after the last strobe.
- Full and hold: hold = 1, push 4 writes -> cmd_ready = 0 after the 4th; a 5th cmd_valid is not accepted. Release hold -> 4 strobes in order; cmd_ready returns to 1 in the cycle after the first pop.
- Swap: swap 22/28 -> exactly one cycle with swap = 1, address_A = 22, address_B = 28, write_en = 0. A write to 22 followed by a swap 22/28 -> write strobe, then swap strobe on the next cycle.
- Degenerate swap: swap 5/5 -> no strobe; drop_count = 1. 300 such swaps -> drop_count = 255.
- Flush: queue 3 commands with hold = 1, assert flush with a simultaneous push -> queue empty, cmd_ready = 1, no strobes after hold release, busy = 0.

Source files
------------

// File: rtl/swap_cmd_sequencer.sv
// Purpose : queues write/swap commands from a host and issues them to the swap
//           register file as single-cycle registered strobes, in FIFO order.
// Latency : command accepted at edge k strobes in the cycle after edge k+1
//           (empty queue, hold low); one issue per cycle when streaming.
// Backpressure: cmd_ready = !full; a full queue refuses pushes even while popping.
// Ports   : clk/reset (async, active-high); cmd_* host handshake; hold/flush issue
//           control; write_en/address_w/data_w and swap/address_A/address_B to the
//           register file; busy and a saturating drop_count of degenerate swaps.
module swap_cmd_sequencer #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] address_w,
    output logic [DATA_WIDTH-1:0] data_w,
    output logic                  swap,
    output logic [ADDR_WIDTH-1:0] address_A,
    output logic [ADDR_WIDTH-1:0] address_B,
    output logic                  busy,
    output logic [7:0]            drop_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                  op;
        logic [ADDR_WIDTH-1:0] addr_a;
        logic [ADDR_WIDTH-1:0] addr_b;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_RUN, ST_PAUSED} state_t;

    state_t                state_q, state_d;
    entry_t                mem_q [FIFO_DEPTH];
    entry_t                mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  write_en_q, write_en_d, swap_q, swap_d;
    logic [ADDR_WIDTH-1:0] address_w_q, address_w_d;
    logic [ADDR_WIDTH-1:0] address_a_q, address_a_d, address_b_q, address_b_d;
    logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
    logic [7:0]            drop_count_q, drop_count_d;

    logic   full, empty, push, pop;
    entry_t head;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    // Fullness is judged on current occupancy only, so a same-cycle pop never frees a slot.
    assign push  = cmd_valid && !full && !flush;
    assign pop   = !empty && !hold && !flush;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        write_en_d   = 1'b0;
        swap_d       = 1'b0;
        address_w_d  = address_w_q;
        data_w_d     = data_w_q;
        address_a_d  = address_a_q;
        address_b_d  = address_b_q;
        drop_count_d = drop_count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{op: cmd_op, addr_a: cmd_addr_a,
                                    addr_b: cmd_addr_b, data: cmd_data};
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (!head.op) begin
                    write_en_d  = 1'b1;
                    address_w_d = head.addr_a;
                    data_w_d    = head.data;
                end else if (head.addr_a != head.addr_b) begin
                    swap_d      = 1'b1;
                    address_a_d = head.addr_a;
                    address_b_d = head.addr_b;
                end else if (drop_count_q != 8'hFF) begin
                    // Swapping a location with itself is a no-op; consume it and count it.
                    drop_count_d = drop_count_q + 8'd1;
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY:  if (push) state_d = ST_RUN;
                ST_RUN: begin
                    if (pop && !push && count_q == CNT_W'(1)) state_d = ST_EMPTY;
                    else if (hold)                           state_d = ST_PAUSED;
                end
                ST_PAUSED: begin
                    // Leaving pause pops in the same cycle, which may drain the last entry.
                    if (!hold) begin
                        if (pop && !push && count_q == CNT_W'(1)) state_d = ST_EMPTY;
                        else                                     state_d = ST_RUN;
                    end
                end
                default:   state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            write_en_q   <= 1'b0;
            swap_q       <= 1'b0;
            address_w_q  <= '0;
            data_w_q     <= '0;
            address_a_q  <= '0;
            address_b_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            write_en_q   <= write_en_d;
            swap_q       <= swap_d;
            address_w_q  <= address_w_d;
            data_w_q     <= data_w_d;
            address_a_q  <= address_a_d;
            address_b_q  <= address_b_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign cmd_ready  = !full;
    assign write_en   = write_en_q;
    assign address_w  = address_w_q;
    assign data_w     = data_w_q;
    assign swap       = swap_q;
    assign address_A  = address_a_q;
    assign address_B  = address_b_q;
    assign drop_count = drop_count_q;
    assign busy       = (state_q != ST_EMPTY) || write_en_q || swap_q;
endmodule
